// File: rtl/eigen_scheduler.sv
// eigen_scheduler: round-robin sharing of one fixed-latency 2x2 eigen core among N_REQ requesters,
// with a tag delay line and a credit-limited FWFT result FIFO. Option macro: EIGEN_SCHED_LAT_CHECK_EN.
module eigen_scheduler #(
  parameter int N_REQ      = 4,
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 16,
  parameter int CORE_LAT   = 14,
  parameter int FIFO_DEPTH = 32,
  localparam int TAG_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [N_REQ*DIN_WIDTH-1:0] req_r11_i,
  input  logic [N_REQ*DIN_WIDTH-1:0] req_r22_i,
  input  logic [N_REQ*DIN_WIDTH-1:0] req_r12_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic [DIN_WIDTH-1:0]       core_r11_o,
  output logic [DIN_WIDTH-1:0]       core_r22_o,
  output logic [DIN_WIDTH-1:0]       core_r12_o,
  output logic                       core_valid_o,
  input  logic [DOUT_WIDTH-1:0]      core_lamb1_i,
  input  logic [DOUT_WIDTH-1:0]      core_lamb2_i,
  input  logic [DOUT_WIDTH-1:0]      core_eig1_y_i,
  input  logic [DOUT_WIDTH-1:0]      core_eig2_y_i,
  input  logic [DOUT_WIDTH-1:0]      core_eig_x_i,
  input  logic                       core_dout_valid_i,
  output logic [DOUT_WIDTH-1:0]      dout_lamb1_o,
  output logic [DOUT_WIDTH-1:0]      dout_lamb2_o,
  output logic [DOUT_WIDTH-1:0]      dout_eig1_y_o,
  output logic [DOUT_WIDTH-1:0]      dout_eig2_y_o,
  output logic [DOUT_WIDTH-1:0]      dout_eig_x_o,
  output logic [TAG_W-1:0]           dout_tag_o,
  output logic                       dout_valid_o,
  input  logic                       dout_ready_i,
`ifdef EIGEN_SCHED_LAT_CHECK_EN
  output logic                       lat_err_o,
`endif
  output logic                       busy_o
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = 5 * DOUT_WIDTH + TAG_W;

  logic [TAG_W-1:0]     ptr_q, win, idx;
  int                   idx_int;
  logic                 found, issue_ok, transfer, push, pop, fifo_empty;
  logic [N_REQ-1:0]     gnt;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIN_WIDTH-1:0] sel_r11, sel_r22, sel_r12;
  logic [DIN_WIDTH-1:0] core_r11_q, core_r22_q, core_r12_q;
  logic                 core_valid_q;
  logic [TAG_W-1:0]     core_tag_q;
  logic [TAG_W:0]       line_q [CORE_LAT];
  logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_q, rd_q;
  logic [ENT_W-1:0]     head;

  // Credit counts everything issued but not yet popped, so the FIFO can never overflow.
  assign issue_ok = (cnt_q < CNT_W'(FIFO_DEPTH));
  assign transfer = found & issue_ok;
  assign push     = line_q[CORE_LAT-1][TAG_W];
  assign fifo_empty = (wr_q == rd_q);
  assign pop      = ~fifo_empty & dout_ready_i;

  always_comb begin
    found   = 1'b0;
    win     = ptr_q;
    idx     = ptr_q;
    idx_int = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx_int = (int'(ptr_q) + k) % N_REQ;
      idx     = TAG_W'(idx_int);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    gnt     = '0;
    sel_r11 = '0;
    sel_r22 = '0;
    sel_r12 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (TAG_W'(i) == win) begin
        gnt[i]  = transfer;
        sel_r11 = req_r11_i[i*DIN_WIDTH +: DIN_WIDTH];
        sel_r22 = req_r22_i[i*DIN_WIDTH +: DIN_WIDTH];
        sel_r12 = req_r12_i[i*DIN_WIDTH +: DIN_WIDTH];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (transfer && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!transfer && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q        <= TAG_W'(N_REQ - 1);
      cnt_q        <= '0;
      core_valid_q <= 1'b0;
      core_r11_q   <= '0;
      core_r22_q   <= '0;
      core_r12_q   <= '0;
      core_tag_q   <= '0;
      for (int s = 0; s < CORE_LAT; s++) line_q[s] <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
    end else begin
      cnt_q        <= cnt_d;
      core_valid_q <= transfer;
      if (transfer) begin
        ptr_q      <= win;
        core_r11_q <= sel_r11;
        core_r22_q <= sel_r22;
        core_r12_q <= sel_r12;
        core_tag_q <= win;
      end
      // Tag line head lines up with the core's result strobe; it alone decides the push.
      line_q[0] <= {core_valid_q, core_tag_q};
      for (int s = 1; s < CORE_LAT; s++) line_q[s] <= line_q[s-1];
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push)
      mem_q[wr_q[AW-1:0]] <= {core_lamb1_i, core_lamb2_i, core_eig1_y_i, core_eig2_y_i,
                              core_eig_x_i, line_q[CORE_LAT-1][TAG_W-1:0]};
  end

  assign head          = fifo_empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign dout_tag_o    = head[TAG_W-1:0];
  assign dout_eig_x_o  = head[TAG_W +: DOUT_WIDTH];
  assign dout_eig2_y_o = head[TAG_W+DOUT_WIDTH +: DOUT_WIDTH];
  assign dout_eig1_y_o = head[TAG_W+2*DOUT_WIDTH +: DOUT_WIDTH];
  assign dout_lamb2_o  = head[TAG_W+3*DOUT_WIDTH +: DOUT_WIDTH];
  assign dout_lamb1_o  = head[TAG_W+4*DOUT_WIDTH +: DOUT_WIDTH];
  assign dout_valid_o  = ~fifo_empty;
  assign req_ready_o   = gnt;
  assign core_valid_o  = core_valid_q;
  assign core_r11_o    = core_r11_q;
  assign core_r22_o    = core_r22_q;
  assign core_r12_o    = core_r12_q;
  assign busy_o        = (cnt_q != '0);

`ifdef EIGEN_SCHED_LAT_CHECK_EN
  logic lat_err_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) lat_err_q <= 1'b0;
    else if (core_dout_valid_i != push) lat_err_q <= 1'b1;
  end
  assign lat_err_o = lat_err_q;
`else
  logic unused_core_dout_valid;
  assign unused_core_dout_valid = core_dout_valid_i;
`endif

endmodule

// File: tb/tb_eigen_scheduler.sv
// Directed bench for eigen_scheduler with a reset-less fixed-latency core stand-in.
module tb_eigen_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] req_r11, req_r22, req_r12;
  logic [3:0]  req_valid, req_ready;
  logic [15:0] core_r11, core_r22, core_r12;
  logic        core_valid;
  logic [15:0] core_lamb1, core_lamb2, core_eig1_y, core_eig2_y, core_eig_x;
  logic        core_dout_valid;
  logic [15:0] dout_lamb1, dout_lamb2, dout_eig1_y, dout_eig2_y, dout_eig_x;
  logic [1:0]  dout_tag;
  logic        dout_valid, dout_ready, busy;
`ifdef EIGEN_SCHED_LAT_CHECK_EN
  logic        lat_err;
`endif
  int total, bad;

  always #5 clk = ~clk;

  eigen_scheduler dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_r11_i(req_r11), .req_r22_i(req_r22), .req_r12_i(req_r12),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .core_r11_o(core_r11), .core_r22_o(core_r22), .core_r12_o(core_r12),
    .core_valid_o(core_valid),
    .core_lamb1_i(core_lamb1), .core_lamb2_i(core_lamb2), .core_eig1_y_i(core_eig1_y),
    .core_eig2_y_i(core_eig2_y), .core_eig_x_i(core_eig_x),
    .core_dout_valid_i(core_dout_valid),
    .dout_lamb1_o(dout_lamb1), .dout_lamb2_o(dout_lamb2), .dout_eig1_y_o(dout_eig1_y),
    .dout_eig2_y_o(dout_eig2_y), .dout_eig_x_o(dout_eig_x),
    .dout_tag_o(dout_tag), .dout_valid_o(dout_valid), .dout_ready_i(dout_ready),
`ifdef EIGEN_SCHED_LAT_CHECK_EN
    .lat_err_o(lat_err),
`endif
    .busy_o(busy)
  );

  // Core stand-in: no reset, latency model_lat, results are simple functions of the operands.
  int          model_lat = 14;
  int          m;
  logic        st_v [20] = '{default: 1'b0};
  logic [15:0] st_a [20], st_b [20], st_c [20];
  always @(posedge clk) begin
    st_v[0] <= core_valid; st_a[0] <= core_r11; st_b[0] <= core_r22; st_c[0] <= core_r12;
    for (int s = 1; s < 20; s++) begin
      st_v[s] <= st_v[s-1]; st_a[s] <= st_a[s-1]; st_b[s] <= st_b[s-1]; st_c[s] <= st_c[s-1];
    end
  end
  assign m               = model_lat - 1;
  assign core_dout_valid = st_v[m];
  assign core_lamb1      = st_a[m] + st_c[m];
  assign core_lamb2      = st_b[m] - st_c[m];
  assign core_eig1_y     = st_a[m] ^ st_b[m];
  assign core_eig2_y     = st_c[m] + 16'd1;
  assign core_eig_x      = st_a[m] + st_b[m];

  function automatic logic [15:0] exp_l1(int t);
    return 16'(4096 * (t + 1) + t);
  endfunction

  task automatic set_all_ops();
    for (int i = 0; i < 4; i++) begin
      req_r11[i*16 +: 16] = 16'(4096 * (i + 1));
      req_r22[i*16 +: 16] = 16'(256 * (i + 1));
      req_r12[i*16 +: 16] = 16'(i);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = '0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rst_req_ready got=%b want=0", req_ready); end
    total++; if (core_valid !== 1'b0) begin bad++; $display("FAIL rst_core_valid got=%b want=0", core_valid); end
    total++; if (core_r11 !== 16'h0) begin bad++; $display("FAIL rst_core_r11 got=%h want=0", core_r11); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rst_dout_valid got=%b want=0", dout_valid); end
    total++; if (dout_tag !== 2'd0) begin bad++; $display("FAIL rst_dout_tag got=%0d want=0", dout_tag); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit early = 0;
    req_r11 = '0; req_r22 = '0; req_r12 = '0;
    req_r11[15:0] = 16'h4000; req_r22[15:0] = 16'h2000;
    req_valid = 4'b0001; dout_ready = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b want=0001", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    total++; if (core_valid !== 1'b1) begin bad++; $display("FAIL single_core_valid got=%b want=1", core_valid); end
    total++; if ({core_r11, core_r22, core_r12} !== {16'h4000, 16'h2000, 16'h0000}) begin
      bad++; $display("FAIL single_operands got=%h %h %h want=4000 2000 0000", core_r11, core_r22, core_r12);
    end
    for (int k = 2; k <= 15; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (k == 2) begin
        total++; if (core_valid !== 1'b0 || core_r11 !== 16'h4000) begin
          bad++; $display("FAIL single_idle_hold got=%b %h want=0 4000", core_valid, core_r11);
        end
      end
      if (dout_valid) early = 1;
    end
    total++; if (early) begin bad++; $display("FAIL single_early_out got=1 want=0"); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (dout_valid !== 1'b1 || dout_tag !== 2'd0) begin
      bad++; $display("FAIL single_out got=%b tag=%0d want=1 tag=0", dout_valid, dout_tag);
    end
    total++; if ({dout_lamb1, dout_lamb2, dout_eig1_y, dout_eig2_y, dout_eig_x} !==
                 {16'h4000, 16'h2000, 16'h6000, 16'h0001, 16'h6000}) begin
      bad++; $display("FAIL single_results got=%h %h %h %h %h want=4000 2000 6000 0001 6000",
                      dout_lamb1, dout_lamb2, dout_eig1_y, dout_eig2_y, dout_eig_x);
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    total++; if (dout_valid !== 1'b1 || dout_lamb1 !== 16'h4000) begin
      bad++; $display("FAIL single_hold got=%b %h want=1 4000", dout_valid, dout_lamb1);
    end
    @(posedge clk); #1 dout_ready = 1'b1;
    @(posedge clk); #1 dout_ready = 1'b0;
    @(negedge clk);
    total++; if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL single_popped got=%b busy=%b want=0 0", dout_valid, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    int n = 0;
    apply_reset(); set_all_ops();
    dout_ready = 1'b1; req_valid = 4'hF;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++; if (req_ready !== (4'b0001 << (i % 4))) begin
        bad++; $display("FAIL fair_grant%0d got=%b want=%b", i, req_ready, 4'b0001 << (i % 4));
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (dout_valid) begin
        total++; if (dout_tag !== 2'(n % 4) || dout_lamb1 !== exp_l1(n % 4)) begin
          bad++; $display("FAIL fair_out%0d got=%0d/%h want=%0d/%h", n, dout_tag, dout_lamb1, n % 4, exp_l1(n % 4));
        end
        n++;
      end
      @(posedge clk); #1;
    end
    total++; if (n != 12 || busy !== 1'b0) begin bad++; $display("FAIL fair_count got=%0d busy=%b want=12 0", n, busy); end
  endtask

  task automatic test_backpressure();
    int acc = 0, acc_w = 0, pops = 0, pops_w = 0;
    apply_reset(); set_all_ops();
    dout_ready = 1'b0; req_valid = 4'hF;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) acc++;
      @(posedge clk); #1;
    end
    total++; if (acc != 32) begin bad++; $display("FAIL bp_accepts got=%0d want=32", acc); end
    @(negedge clk);
    total++; if (req_ready !== 4'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL bp_stalled got=%b busy=%b want=0000 1", req_ready, busy);
    end
    @(posedge clk); #1 dout_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin acc++; acc_w++; end
      if (dout_valid) begin
        total++; if (dout_tag !== 2'(pops % 4)) begin
          bad++; $display("FAIL bp_tag%0d got=%0d want=%0d", pops, dout_tag, pops % 4);
        end
        pops++; pops_w++;
      end
      @(posedge clk); #1;
    end
    total++; if (acc_w != 39 || pops_w != 40) begin
      bad++; $display("FAIL bp_rate got=%0d/%0d want=39/40", acc_w, pops_w);
    end
    req_valid = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (dout_valid) begin
        total++; if (dout_tag !== 2'(pops % 4)) begin
          bad++; $display("FAIL bp_tag%0d got=%0d want=%0d", pops, dout_tag, pops % 4);
        end
        pops++;
      end
      @(posedge clk); #1;
    end
    total++; if (pops != 71 || acc != 71) begin
      bad++; $display("FAIL bp_total got=%0d pops %0d accepts want=71 71", pops, acc);
    end
  endtask

  task automatic test_simultaneous();
    int acc = 0, n = 1, guard = 0;
    apply_reset(); set_all_ops();
    dout_ready = 1'b0; req_valid = 4'hF;
    while (acc < 31 && guard < 60) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) acc++;
      @(posedge clk); #1;
      guard++;
    end
    req_valid = '0;
    total++; if (acc != 31) begin bad++; $display("FAIL sim_fill got=%0d want=31", acc); end
    repeat (20) begin @(posedge clk); #1; end
    req_valid = 4'b0001;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL sim_last_credit got=%b want=0001", req_ready); end
    @(posedge clk); #1 req_valid = 4'hF;
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL sim_no_credit got=%b want=0000", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    repeat (13) begin @(posedge clk); #1; end
    dout_ready = 1'b1;
    @(negedge clk);
    total++; if (dout_valid !== 1'b1 || dout_tag !== 2'd0) begin
      bad++; $display("FAIL sim_head got=%b tag=%0d want=1 tag=0", dout_valid, dout_tag);
    end
    @(posedge clk); #1 dout_ready = 1'b0;
    @(posedge clk); #1 dout_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (dout_valid) begin
        total++; if (dout_tag !== ((n < 31) ? 2'(n % 4) : 2'd0) || dout_lamb1 !== exp_l1((n < 31) ? n % 4 : 0)) begin
          bad++; $display("FAIL sim_out%0d got=%0d/%h want=%0d", n, dout_tag, dout_lamb1, (n < 31) ? n % 4 : 0);
        end
        n++;
      end
      @(posedge clk); #1;
    end
    total++; if (n != 32) begin bad++; $display("FAIL sim_count got=%0d want=32", n); end
  endtask

  task automatic test_reset_midflight();
    bit seen = 0;
    apply_reset(); set_all_ops();
    req_valid = 4'hF;
    repeat (5) begin @(posedge clk); #1; end
    req_valid = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 4'b0 || core_valid !== 1'b0 || core_r11 !== 16'h0) begin
      bad++; $display("FAIL mid_rst_issue got=%b %b %h want=0000 0 0000", req_ready, core_valid, core_r11);
    end
    total++; if (dout_valid !== 1'b0 || dout_tag !== 2'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_rst_out got=%b %0d %b want=0 0 0", dout_valid, dout_tag, busy);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    dout_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (dout_valid || busy) seen = 1;
      @(posedge clk); #1;
    end
    total++; if (seen) begin bad++; $display("FAIL mid_stale_out got=1 want=0"); end
  endtask

`ifdef EIGEN_SCHED_LAT_CHECK_EN
  task automatic test_lat_check();
    apply_reset(); set_all_ops();
    model_lat = 15;
    req_valid = 4'b0001;
    @(posedge clk); #1 req_valid = '0;
    repeat (14) begin @(posedge clk); #1; end
    @(negedge clk);
    total++; if (lat_err !== 1'b0) begin bad++; $display("FAIL lat_before got=%b want=0", lat_err); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (lat_err !== 1'b1 || dout_valid !== 1'b1) begin
      bad++; $display("FAIL lat_set got=%b dv=%b want=1 1", lat_err, dout_valid);
    end
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    total++; if (lat_err !== 1'b1) begin bad++; $display("FAIL lat_sticky got=%b want=1", lat_err); end
    @(posedge clk); #1;
    model_lat = 14;
    apply_reset();
    @(negedge clk);
    total++; if (lat_err !== 1'b0) begin bad++; $display("FAIL lat_cleared got=%b want=0", lat_err); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; req_valid = '0; dout_ready = 1'b0;
    req_r11 = '0; req_r22 = '0; req_r12 = '0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_simultaneous();
    test_reset_midflight();
`ifdef EIGEN_SCHED_LAT_CHECK_EN
    test_lat_check();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
